// File: rtl/lab8_pc_unit_if.sv
// Control-side bundle for the PC unit: next-PC request in, fetch PC and RAS status out.
// master = control unit (drives stall/op/take/offset/target), slave = lab8_pc_unit.
interface lab8_pc_unit_if #(
    parameter int WIDTH = 8
);
    logic             stall;
    logic [2:0]       op;
    logic             take;
    logic [WIDTH-1:0] offset;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pc;
    logic             cout;
    logic             ras_full;
    logic             ras_empty;
    logic             ras_err;

    modport master (
        output stall, op, take, offset, target,
        input  pc, cout, ras_full, ras_empty, ras_err
    );

    modport slave (
        input  stall, op, take, offset, target,
        output pc, cout, ras_full, ras_empty, ras_err
    );
endinterface

// File: rtl/lab8_pc_unit.sv
// Program-counter unit: SEQ/BRANCH/JUMP/CALL/RET with a circular return-address stack.
// Ports: clk, reset (sync, active-high), bus (slave): stall/op/take/offset/target in; pc/cout/ras_* out.
module lab8_pc_unit #(
    parameter int WIDTH     = 8,
    parameter int STEP      = 4,
    parameter int RAS_DEPTH = 4,
    parameter int RESET_VEC = 0
) (
    input  logic             clk,
    input  logic             reset,
    lab8_pc_unit_if.slave    bus
);
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    localparam logic [2:0] OP_BR   = 3'd1;
    localparam logic [2:0] OP_JMP  = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]    wp_q, wp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cout_q, cout_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic [WIDTH:0]   seq_w, br_w;
    logic [PW-1:0]    wp_inc, wp_dec;
    logic             full, empty;
    logic             ras_we;

    assign seq_w = {1'b0, pc_q} + (WIDTH+1)'(STEP);
    assign br_w  = {1'b0, pc_q} + {1'b0, bus.offset};

    // Pointer wrap done explicitly so non-power-of-two depths work.
    assign wp_inc = (wp_q == PW'(RAS_DEPTH - 1)) ? '0 : wp_q + 1'b1;
    assign wp_dec = (wp_q == '0) ? PW'(RAS_DEPTH - 1) : wp_q - 1'b1;

    assign full  = (cnt_q == CW'(RAS_DEPTH));
    assign empty = (cnt_q == '0);

    always_comb begin
        pc_d   = pc_q;
        wp_d   = wp_q;
        cnt_d  = cnt_q;
        cout_d = 1'b0;
        err_d  = 1'b0;
        ras_we = 1'b0;
        if (!bus.stall) begin
            pc_d = seq_w[WIDTH-1:0];
            case (bus.op)
                OP_BR: begin
                    if (bus.take) begin
                        pc_d   = br_w[WIDTH-1:0];
                        cout_d = br_w[WIDTH];
                    end
                end
                OP_JMP: pc_d = bus.target;
                OP_CALL: begin
                    // When full, the write slot is the oldest entry: it is overwritten.
                    pc_d   = bus.target;
                    ras_we = 1'b1;
                    wp_d   = wp_inc;
                    if (full) err_d = 1'b1;
                    else      cnt_d = cnt_q + 1'b1;
                end
                OP_RET: begin
                    if (empty) begin
                        err_d = 1'b1;
                    end else begin
                        pc_d  = ras_q[wp_dec];
                        wp_d  = wp_dec;
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= WIDTH'(RESET_VEC);
            wp_q   <= '0;
            cnt_q  <= '0;
            cout_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            wp_q   <= wp_d;
            cnt_q  <= cnt_d;
            cout_q <= cout_d;
            err_q  <= err_d;
        end
    end

    // Stack storage carries no reset; entries are only read when count > 0.
    always_ff @(posedge clk) begin
        if (ras_we && !reset) ras_q[wp_q] <= seq_w[WIDTH-1:0];
    end

    assign bus.pc        = pc_q;
    assign bus.cout      = cout_q;
    assign bus.ras_err   = err_q;
    assign bus.ras_full  = full;
    assign bus.ras_empty = empty;
endmodule

// File: tb/tb_lab8_pc_unit.sv
// Bench for lab8_pc_unit: directed walk through the key scenarios, then random ops
// checked against a queue-based model of the PC and return-address stack.
module tb_lab8_pc_unit;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    lab8_pc_unit_if #(.WIDTH(8)) bus ();

    lab8_pc_unit #(
        .WIDTH(8), .STEP(4), .RAS_DEPTH(DEPTH), .RESET_VEC(0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int m_pc;
    int m_cout;
    int m_err;
    int m_ras[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic model(bit r, bit s, int op, bit t, int off, int tgt);
        int seq;
        int sum;
        seq    = (m_pc + 4) % 256;
        sum    = m_pc + off;
        m_cout = 0;
        m_err  = 0;
        if (r) begin
            m_pc = 0;
            m_ras.delete();
        end else if (!s) begin
            case (op)
                1: begin
                    if (t) begin
                        m_pc   = sum % 256;
                        m_cout = sum / 256;
                    end else m_pc = seq;
                end
                2: m_pc = tgt;
                3: begin
                    m_ras.push_back(seq);
                    if (m_ras.size() > DEPTH) begin
                        void'(m_ras.pop_front());
                        m_err = 1;
                    end
                    m_pc = tgt;
                end
                4: begin
                    if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                    else begin
                        m_pc  = seq;
                        m_err = 1;
                    end
                end
                default: m_pc = seq;
            endcase
        end
    endtask

    task automatic cyc(string tag, bit r, bit s, int op, bit t, int off, int tgt);
        @(negedge clk);
        reset      = r;
        bus.stall  = s;
        bus.op     = 3'(op);
        bus.take   = t;
        bus.offset = 8'(off);
        bus.target = 8'(tgt);
        model(r, s, op, t, off, tgt);
        @(posedge clk);
        #1;
        chk({tag, ".pc"},    32'(bus.pc),        32'(m_pc));
        chk({tag, ".cout"},  32'(bus.cout),      32'(m_cout));
        chk({tag, ".err"},   32'(bus.ras_err),   32'(m_err));
        chk({tag, ".full"},  32'(bus.ras_full),  32'(m_ras.size() == DEPTH));
        chk({tag, ".empty"}, 32'(bus.ras_empty), 32'(m_ras.size() == 0));
    endtask

    initial begin
        m_pc = 0;
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.op = 3'd0;
        bus.take = 1'b0;
        bus.offset = '0;
        bus.target = '0;

        cyc("rst", 1, 0, 0, 0, 0, 0);
        chk("rst_pc", 32'(bus.pc), 32'h00);
        chk("rst_empty", 32'(bus.ras_empty), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            cyc("seq", 0, 0, 0, 0, 0, 0);
            chk("seq_pc", 32'(bus.pc), 32'(4 * i));
        end

        cyc("j_fc", 0, 0, 2, 0, 0, 'hFC);
        cyc("wrap", 0, 0, 0, 0, 0, 0);
        chk("wrap_pc", 32'(bus.pc), 32'h00);
        cyc("j_f0", 0, 0, 2, 0, 0, 'hF0);
        cyc("br_fwd", 0, 0, 1, 1, 'h20, 0);
        chk("br_fwd_pc", 32'(bus.pc), 32'h10);
        chk("br_fwd_cout", 32'(bus.cout), 32'd1);
        cyc("br_back", 0, 0, 1, 1, 'hF8, 0);
        chk("br_back_pc", 32'(bus.pc), 32'h08);
        chk("br_back_cout", 32'(bus.cout), 32'd1);
        cyc("br_nt", 0, 0, 1, 0, 'h40, 0);
        chk("br_nt_pc", 32'(bus.pc), 32'h0C);
        chk("br_nt_cout", 32'(bus.cout), 32'd0);

        cyc("j_10", 0, 0, 2, 0, 0, 'h10);
        cyc("call1", 0, 0, 3, 0, 0, 'h40);
        cyc("call2", 0, 0, 3, 0, 0, 'h80);
        cyc("ret1", 0, 0, 4, 0, 0, 0);
        chk("ret1_pc", 32'(bus.pc), 32'h44);
        cyc("ret2", 0, 0, 4, 0, 0, 0);
        chk("ret2_pc", 32'(bus.pc), 32'h14);
        chk("ret2_empty", 32'(bus.ras_empty), 32'd1);

        cyc("j_00", 0, 0, 2, 0, 0, 'h00);
        for (int i = 1; i <= 5; i++) begin
            cyc("callx", 0, 0, 3, 0, 0, 'h40);
            if (i == 4) chk("full4", 32'(bus.ras_full), 32'd1);
            if (i == 5) chk("ovf_err", 32'(bus.ras_err), 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            cyc("retx", 0, 0, 4, 0, 0, 0);
            chk("retx_pc", 32'(bus.pc), 32'h44);
        end

        cyc("j_20", 0, 0, 2, 0, 0, 'h20);
        cyc("ret_e", 0, 0, 4, 0, 0, 0);
        chk("ret_e_pc", 32'(bus.pc), 32'h24);
        chk("ret_e_err", 32'(bus.ras_err), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc("stall", 0, 1, 2, 0, 0, 'h99);
            chk("stall_pc", 32'(bus.pc), 32'h24);
        end

        cyc("c_a", 0, 0, 3, 0, 0, 'h30);
        cyc("c_b", 0, 0, 3, 0, 0, 'h50);
        cyc("rst_ret", 1, 0, 4, 0, 0, 0);
        chk("rst_ret_pc", 32'(bus.pc), 32'h00);
        cyc("ret_after", 0, 0, 4, 0, 0, 0);
        chk("ret_after_pc", 32'(bus.pc), 32'h04);
        chk("ret_after_err", 32'(bus.ras_err), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            cyc("rnd",
                ($urandom_range(0, 99) == 0),
                ($urandom_range(0, 7) == 0),
                int'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)),
                int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
